// File: rtl/acia_peer_pkg.sv
// Shared constants and state encodings for the ACIA peer endpoint.
// Both FSMs run on the internal 16x oversampling tick.
package acia_peer_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int FRAME_BITS = 10;
    localparam int START_HALF = 7;
    localparam int SUB_W      = $clog2(OVERSAMPLE);

    typedef logic [SUB_W-1:0] sub_t;

    typedef enum logic [2:0] {
        RX_ST_IDLE  = 3'd0,
        RX_ST_START = 3'd1,
        RX_ST_DATA  = 3'd2,
        RX_ST_STOP  = 3'd3,
        RX_ST_WAIT  = 3'd4
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_ST_IDLE  = 2'd0,
        TX_ST_SHIFT = 2'd1,
        TX_ST_GAP   = 2'd2
    } tx_state_t;

endpackage

// File: rtl/acia_peer_fifo.sv
// First-word fall-through FIFO; pop_data shows the head whenever empty is low.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module acia_peer_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];
    assign rd_en    = pop && !empty;
    assign wr_en    = push && (!full || rd_en);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/acia_peer.sv
// Device-side 8N1 endpoint at the far end of the ACIA link: receives on rx,
// transmits on tx, and exchanges bytes with the IO controller through FIFOs.
module acia_peer #(
    parameter int DIV_SLOW   = 256,
    parameter int DIV_FAST   = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int TX_GAP     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       baud_sel,
    input  logic       rx,
    output logic       tx,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic       err_clr,
    output logic       rx_overrun,
    output logic       rx_frame_err
);

    import acia_peer_pkg::*;

    // Handshakes: a byte moves on any cycle where valid and ready are both high
    // at the rising clock edge; valid never depends on ready.

    localparam int DIV_MAX   = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
    localparam int CW        = $clog2(DIV_MAX);
    localparam int GAP_TICKS = (TX_GAP > 0) ? TX_GAP * OVERSAMPLE : 1;
    localparam int GAP_W     = $clog2(GAP_TICKS + 1);
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CW-1:0]    RELOAD_SLOW = CW'(DIV_SLOW - 1);
    localparam logic [CW-1:0]    RELOAD_FAST = CW'(DIV_FAST - 1);
    localparam sub_t             SUB_LAST    = sub_t'(OVERSAMPLE - 1);
    localparam sub_t             SUB_HALF    = sub_t'(START_HALF);
    localparam logic [3:0]       TX_LAST_BIT = 4'(FRAME_BITS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(GAP_TICKS - 1);

    // ------------------------------------------------------------------
    // 16x tick: a rate change restarts the period instead of ticking.
    logic [CW-1:0] tick_cnt;
    logic          baud_q;
    logic          tick;

    assign tick = enable && (baud_sel == baud_q) && (tick_cnt == '0);

    always_ff @(posedge clk) begin
        baud_q <= baud_sel;
        if (reset || !enable) begin
            tick_cnt <= '0;
        end else if ((baud_sel != baud_q) || (tick_cnt == '0)) begin
            tick_cnt <= baud_sel ? RELOAD_FAST : RELOAD_SLOW;
        end else begin
            tick_cnt <= tick_cnt - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // RX front end: synchronizer, then a 3-sample majority-free filter that
    // only changes level on three agreeing samples.
    logic       rx_s1;
    logic       rx_s2;
    logic [2:0] rx_hist;
    logic [2:0] rx_hist_next;
    logic       rxf;

    assign rx_hist_next = {rx_hist[1:0], rx_s2};

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_hist <= 3'b111;
            rxf     <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            if (tick) begin
                rx_hist <= rx_hist_next;
                if (rx_hist_next == 3'b000) begin
                    rxf <= 1'b0;
                end else if (rx_hist_next == 3'b111) begin
                    rxf <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFOs
    logic             rx_push;
    logic             rx_pop;
    logic             rx_full;
    logic             rx_empty;
    logic [CNT_W-1:0] rx_count;
    logic [7:0]       rx_byte;

    logic             tx_push;
    logic             tx_pop;
    logic             tx_full;
    logic             tx_empty;
    logic [CNT_W-1:0] tx_count;
    logic [7:0]       tx_head;

    logic             unused_counts;

    assign rx_valid      = !rx_empty;
    assign rx_pop        = rx_valid && rx_ready;
    assign tx_ready      = !tx_full;
    assign tx_push       = tx_valid && tx_ready;
    assign unused_counts = ^{rx_count, tx_count};

    acia_peer_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_push),
        .push_data (rx_byte),
        .pop       (rx_pop),
        .pop_data  (rx_data),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    acia_peer_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_push),
        .push_data (tx_data),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    // ------------------------------------------------------------------
    // RX FSM: all sampling happens at sub==0 on a tick.
    rx_state_t  rx_state;
    sub_t       rx_sub;
    logic [2:0] rx_bit;
    logic       rx_stop_sample;
    logic       overrun_set;
    logic       frame_set;

    assign rx_stop_sample = tick && (rx_state == RX_ST_STOP) && (rx_sub == '0);
    assign rx_push        = rx_stop_sample && rxf;
    assign overrun_set    = rx_push && rx_full && !rx_pop;
    assign frame_set      = rx_stop_sample && !rxf;

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            rx_state <= RX_ST_IDLE;
            rx_sub   <= '0;
            rx_bit   <= '0;
            rx_byte  <= '0;
        end else if (tick) begin
            case (rx_state)
                RX_ST_IDLE: begin
                    if (!rxf) begin
                        rx_state <= RX_ST_START;
                        rx_sub   <= SUB_HALF;
                    end
                end
                RX_ST_START: begin
                    if (rx_sub != '0) begin
                        rx_sub <= rx_sub - 1'b1;
                    end else if (!rxf) begin
                        rx_state <= RX_ST_DATA;
                        rx_sub   <= SUB_LAST;
                        rx_bit   <= '0;
                    end else begin
                        rx_state <= RX_ST_IDLE;
                    end
                end
                RX_ST_DATA: begin
                    if (rx_sub != '0) begin
                        rx_sub <= rx_sub - 1'b1;
                    end else begin
                        rx_byte <= {rxf, rx_byte[7:1]};
                        rx_sub  <= SUB_LAST;
                        rx_bit  <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7) begin
                            rx_state <= RX_ST_STOP;
                        end
                    end
                end
                RX_ST_STOP: begin
                    if (rx_sub != '0) begin
                        rx_sub <= rx_sub - 1'b1;
                    end else begin
                        rx_state <= rxf ? RX_ST_IDLE : RX_ST_WAIT;
                    end
                end
                RX_ST_WAIT: begin
                    if (rxf) begin
                        rx_state <= RX_ST_IDLE;
                    end
                end
                default: rx_state <= RX_ST_IDLE;
            endcase
        end
    end

    // Sticky error flags; a set in the same cycle as err_clr takes priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (overrun_set) begin
                rx_overrun <= 1'b1;
            end else if (err_clr) begin
                rx_overrun <= 1'b0;
            end
            if (frame_set) begin
                rx_frame_err <= 1'b1;
            end else if (err_clr) begin
                rx_frame_err <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // TX FSM: the shift register idles at all ones, so tx is simply its LSB.
    tx_state_t             tx_state;
    logic [FRAME_BITS-1:0] tx_shift;
    sub_t                  tx_sub;
    logic [3:0]            tx_bit;
    logic [GAP_W-1:0]      tx_gap_cnt;

    assign tx_pop = tick && (tx_state == TX_ST_IDLE) && !tx_empty;
    assign tx     = tx_shift[0];

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            tx_state   <= TX_ST_IDLE;
            tx_shift   <= '1;
            tx_sub     <= '0;
            tx_bit     <= '0;
            tx_gap_cnt <= '0;
        end else if (tick) begin
            case (tx_state)
                TX_ST_IDLE: begin
                    if (!tx_empty) begin
                        tx_shift <= {1'b1, tx_head, 1'b0};
                        tx_sub   <= SUB_LAST;
                        tx_bit   <= '0;
                        tx_state <= TX_ST_SHIFT;
                    end
                end
                TX_ST_SHIFT: begin
                    if (tx_sub != '0) begin
                        tx_sub <= tx_sub - 1'b1;
                    end else begin
                        tx_shift <= {1'b1, tx_shift[FRAME_BITS-1:1]};
                        tx_sub   <= SUB_LAST;
                        tx_bit   <= tx_bit + 1'b1;
                        if (tx_bit == TX_LAST_BIT) begin
                            if (TX_GAP > 0) begin
                                tx_state   <= TX_ST_GAP;
                                tx_gap_cnt <= GAP_LAST;
                            end else begin
                                tx_state <= TX_ST_IDLE;
                            end
                        end
                    end
                end
                TX_ST_GAP: begin
                    if (tx_gap_cnt != '0) begin
                        tx_gap_cnt <= tx_gap_cnt - 1'b1;
                    end else begin
                        tx_state <= TX_ST_IDLE;
                    end
                end
                default: tx_state <= TX_ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acia_peer.sv
// Directed-plus-random bench for acia_peer: serial frames are built and decoded
// at the bit level and compared with a byte-queue model of both FIFOs.
module tb_acia_peer;

    localparam int DIV_S = 32;
    localparam int DIV_F = 8;
    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       baud_sel;
    logic       rx;
    logic       tx;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       err_clr;
    logic       rx_overrun;
    logic       rx_frame_err;

    int vectors;
    int miscompares;
    int div_cur;
    int cyc;

    logic [7:0] exp_q[$];
    logic [7:0] exp_tx_q[$];
    logic       exp_overrun;
    logic       exp_frame;

    acia_peer #(
        .DIV_SLOW   (DIV_S),
        .DIV_FAST   (DIV_F),
        .FIFO_DEPTH (DEPTH),
        .TX_GAP     (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .baud_sel     (baud_sel),
        .rx           (rx),
        .tx           (tx),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .err_clr      (err_clr),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err)
    );

    // Clock and cycle count
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no end of test, required finish within budget");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * 16 * div_cur) @(negedge clk);
    endtask

    // 8N1 frame with each bit edge displaced by -1..+1 tick around its nominal time.
    task automatic send_frame(input logic [7:0] b, input logic stop_val);
        logic [9:0] bits;
        int jp;
        int jn;
        bits = {stop_val, b, 1'b0};
        jp = 0;
        for (int k = 0; k < 10; k++) begin
            jn = (k == 9) ? 0 : int'($urandom_range(2)) - 1;
            rx = bits[k];
            repeat (16 * div_cur + (jn - jp) * div_cur) @(negedge clk);
            jp = jn;
        end
        rx = 1'b1;
    endtask

    // Reference model of what the device should do with a received frame.
    task automatic model_frame(input logic [7:0] b, input logic stop_val);
        if (!stop_val) exp_frame = 1'b1;
        else if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_overrun = 1'b1;
    endtask

    task automatic wait_rx_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (rx_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rise"}, rx_valid, 1);
    endtask

    task automatic drain_rx(input string tag);
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, rx_valid, 1);
            check({tag, "_data"}, rx_data, e);
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
        check({tag, "_empty"}, rx_valid, 0);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_overrun = 1'b0;
        exp_frame = 1'b0;
        @(negedge clk);
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_data = b;
        tx_valid = 1'b1;
        if (exp_tx_q.size() < DEPTH) exp_tx_q.push_back(b);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Decode one frame on tx by sampling each bit at its middle.
    task automatic tx_capture(input string tag, output int fall_cyc, output int start_len);
        logic [9:0] bits;
        logic [7:0] e;
        int bitc;
        int n;
        bitc = 16 * div_cur;
        bits = '1;
        n = 0;
        start_len = -1;
        fall_cyc = 0;
        while (tx !== 1'b0 && n < 14 * bitc) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_start_seen"}, tx, 0);
        if (tx !== 1'b0) return;
        fall_cyc = cyc;
        for (int c = 0; c < 10 * bitc; c++) begin
            if (start_len < 0 && tx === 1'b1) start_len = c;
            if (c % bitc == bitc / 2) bits[c / bitc] = tx;
            @(negedge clk);
        end
        e = (exp_tx_q.size() > 0) ? exp_tx_q.pop_front() : 8'hxx;
        check({tag, "_start_bit"}, bits[0], 0);
        check({tag, "_data"}, bits[8:1], e);
        check({tag, "_stop_bit"}, bits[9], 1);
    endtask

    initial begin
        int f1;
        int f2;
        int s1;
        int s2;
        int lows;
        int n;
        logic [7:0] b;

        vectors = 0;
        miscompares = 0;
        exp_overrun = 1'b0;
        exp_frame = 1'b0;
        reset = 1'b1;
        enable = 1'b0;
        baud_sel = 1'b1;
        div_cur = DIV_F;
        rx = 1'b1;
        tx_data = '0;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        err_clr = 1'b0;
        repeat (4) @(negedge clk);

        // Reset state
        check("rst_tx", tx, 1);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_overrun", rx_overrun, 0);
        check("rst_frame_err", rx_frame_err, 0);
        reset = 1'b0;
        enable = 1'b1;
        repeat (4) @(negedge clk);

        // TX basic: 0xA5 then a random byte, fast rate
        push_tx(8'hA5);
        push_tx(8'($urandom_range(255)));
        tx_capture("tx_a5", f1, s1);
        check("tx_a5_start_len", s1, 16 * DIV_F);
        tx_capture("tx_rand", f2, s2);
        check("tx_gap_min", (f2 - f1) >= 11 * 16 * DIV_F, 1);
        check("tx_gap_max", (f2 - f1) <= 12 * 16 * DIV_F, 1);

        // TX at the slow rate
        baud_sel = 1'b0;
        div_cur = DIV_S;
        repeat (4) @(negedge clk);
        push_tx(8'($urandom_range(255)));
        tx_capture("tx_slow", f1, s1);
        baud_sel = 1'b1;
        div_cur = DIV_F;
        idle_bits(2);

        // RX basic: 0x3C then random bytes, one at a time
        send_frame(8'h3C, 1'b1);
        model_frame(8'h3C, 1'b1);
        wait_rx_valid("rx_3c", 8 * div_cur);
        check("rx_3c_overrun", rx_overrun, exp_overrun);
        check("rx_3c_frame", rx_frame_err, exp_frame);
        drain_rx("rx_3c");
        for (int i = 0; i < 3; i++) begin
            idle_bits(1);
            b = 8'($urandom_range(255));
            send_frame(b, 1'b1);
            model_frame(b, 1'b1);
            wait_rx_valid("rx_rand", 8 * div_cur);
            drain_rx("rx_rand");
        end

        // RX at the slow rate
        baud_sel = 1'b0;
        div_cur = DIV_S;
        idle_bits(1);
        b = 8'($urandom_range(255));
        send_frame(b, 1'b1);
        model_frame(b, 1'b1);
        wait_rx_valid("rx_slow", 8 * div_cur);
        drain_rx("rx_slow");
        baud_sel = 1'b1;
        div_cur = DIV_F;
        idle_bits(1);

        // Overrun: five frames into a four-entry FIFO with no consumer
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom_range(255));
            send_frame(b, 1'b1);
            model_frame(b, 1'b1);
            idle_bits(1);
            if (i == 3) check("ovr_not_yet", rx_overrun, exp_overrun);
        end
        check("ovr_flag", rx_overrun, exp_overrun);
        check("ovr_frame", rx_frame_err, exp_frame);
        drain_rx("ovr");
        pulse_err_clr();
        check("ovr_cleared", rx_overrun, exp_overrun);

        // Framing error, then a clean frame
        send_frame(8'h55, 1'b0);
        model_frame(8'h55, 1'b0);
        idle_bits(2);
        check("frm_flag", rx_frame_err, exp_frame);
        check("frm_no_push", rx_valid, exp_q.size() > 0);
        send_frame(8'h12, 1'b1);
        model_frame(8'h12, 1'b1);
        wait_rx_valid("frm_next", 8 * div_cur);
        drain_rx("frm_next");
        check("frm_sticky", rx_frame_err, exp_frame);
        pulse_err_clr();
        check("frm_cleared", rx_frame_err, exp_frame);

        // Glitch: two-tick low pulse must not start a frame
        idle_bits(1);
        rx = 1'b0;
        repeat (2 * div_cur) @(negedge clk);
        rx = 1'b1;
        idle_bits(12);
        check("glitch_no_push", rx_valid, 0);
        check("glitch_overrun", rx_overrun, 0);
        check("glitch_frame", rx_frame_err, 0);

        // Back-to-back pushes with the tick stopped, then reset mid-frame
        enable = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) push_tx(8'($urandom_range(255)));
        check("b2b_full", tx_ready, exp_tx_q.size() < DEPTH);
        push_tx(8'hEE);
        check("b2b_refused", exp_tx_q.size(), DEPTH);
        enable = 1'b1;
        n = 0;
        while (tx !== 1'b0 && n < 4 * 16 * div_cur) begin
            @(negedge clk);
            n++;
        end
        check("b2b_start_seen", tx, 0);
        void'(exp_tx_q.pop_front());
        check("b2b_ready_after_pop", tx_ready, exp_tx_q.size() < DEPTH);
        repeat (3 * 16 * div_cur) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_tx_q.delete();
        check("mid_rst_tx", tx, 1);
        check("mid_rst_tx_ready", tx_ready, 1);
        check("mid_rst_rx_valid", rx_valid, 0);
        lows = 0;
        repeat (12 * 16 * div_cur) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("mid_rst_tx_quiet", lows, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/acia_peer.md
Name: acia_peer

Overview:
- Device-side 8N1 serial endpoint that sits at the far end of the ACIA link and emulates the peripheral (iKBD / MIDI device) the ACIA talks to.
- Receives frames on the ACIA tx line and transmits frames onto the ACIA rx line.
- Exchanges bytes with the IO controller through small FWFT FIFOs using valid/ready handshakes.
- Single clock domain; the 16x oversampling tick is generated internally.

Parameters:
- DIV_SLOW, 256: clk cycles per 16x tick when baud_sel=0 (32 MHz -> 7812.5 bps).
- DIV_FAST, 64: clk cycles per 16x tick when baud_sel=1 (32 MHz -> 31250 bps).
- FIFO_DEPTH, 4: entries in each FIFO; must be a power of 2, at least 2.
- TX_GAP, 1: extra idle (mark) bit times inserted after every transmitted stop bit.

Ports:
- clk, in, 1: system clock (32 MHz).
- reset, in, 1: synchronous, active-high reset.
- enable, in, 1: 0 holds both FSMs idle and the tick counter cleared. FIFO contents are retained.
- baud_sel, in, 1: 0 = slow rate, 1 = fast rate.
- rx, in, 1: serial in, asynchronous; connected to the ACIA tx.
- tx, out, 1: serial out; connected to the ACIA rx.
- tx_data, in, 8: byte from the IO controller.
- tx_valid, in, 1: tx_data is valid.
- tx_ready, out, 1: asserted when the TX FIFO is not full.
- rx_data, out, 8: head of the RX FIFO.
- rx_valid, out, 1: asserted when the RX FIFO is not empty.
- rx_ready, in, 1: consumer accepts the head entry.
- err_clr, in, 1: one-cycle pulse that clears the sticky error flags.
- rx_overrun, out, 1: sticky; a byte was dropped because the RX FIFO was full.
- rx_frame_err, out, 1: sticky; a stop bit was sampled as 0.

Behaviour:
- Reset values: tx=1, tx_ready=1, rx_valid=0, rx_data=0, both error flags 0, both FIFOs empty, tick counter 0, both FSMs idle.
- Tick generation:
  - Down-counter reloads to DIV-1, with DIV selected by baud_sel.
  - tick is a 1-clk pulse when the counter reaches 0.
  - Any change of baud_sel reloads the counter without emitting a tick.
- RX front end:
  - 2-flop synchronizer on rx.
  - On each tick, shift the synced bit into a 3-bit history.
  - rxf (filtered level) becomes 0 when the history is 000 and 1 when it is 111; otherwise it holds. Reset value of rxf is 1.
- RX FSM (all transitions on tick only):
  - IDLE: if rxf=0, go to START with sub=7.
  - START: decrement sub. At sub=0: if rxf=0, go to DATA with sub=15, bit=0; otherwise return to IDLE (glitch rejected).
  - DATA: at sub=0, shift rxf into the MSB of the shift register (LSB-first framing) and reload sub=15. After the 8th bit, go to STOP.
  - STOP: at sub=0:
    - rxf=1: push the byte and go to IDLE. If the FIFO is full and no pop happens in the same cycle, drop the byte, set rx_overrun, and go to IDLE.
    - rxf=0: set rx_frame_err, discard the byte, go to WAIT.
  - WAIT: when rxf=1, go to IDLE.
- TX FSM:
  - IDLE: on tick with the TX FIFO non-empty, pop it, load shift={1,data,0}, set sub=15, bit=0, go to SHIFT.
  - SHIFT: each tick decrements sub. At sub=0, shift right filling with 1 and increment bit. After 10 bits, go to GAP.
  - GAP: hold for TX_GAP*16 ticks, then go to IDLE.
  - tx = shift[0], registered. The start bit appears 1 clk after the loading tick.
- FIFO rules:
  - First-word fall-through; rx_data is valid in the same cycle rx_valid rises.
  - Push occurs on tx_valid & tx_ready.
  - Pop occurs on rx_valid & rx_ready.
  - Simultaneous push and pop at full is legal on the RX side: the count is unchanged and there is no overrun.
  - Simultaneous push and pop at empty is not permitted; rx_valid gates the pop.
  - Pointers wrap modulo FIFO_DEPTH; the count is log2(DEPTH)+1 bits wide.
- Error flags: a set event in the same cycle as err_clr wins.
- enable low mid-frame:
  - RX returns to IDLE and the partial byte is lost without any flag.
  - TX aborts to IDLE with tx=1; the popped byte is lost.
- reset mid-frame: same as power-on reset.

Decomposition:
- Package acia_peer_pkg holds:
  - RX state enum: IDLE, START, DATA, STOP, WAIT.
  - TX state enum: IDLE, SHIFT, GAP.
  - Constants: OVERSAMPLE=16, FRAME_BITS=10, START_HALF=7.
- One sub-module, acia_peer_fifo:
  - Parameterised depth and width.
  - FWFT, with full/empty/count outputs and synchronous reset.
  - Instantiated twice.

Test Plan:
- TX basic: baud_sel=1, push 0xA5 -> tx goes low 1024 clk; then bits 1,0,1,0,0,1,0,1 at 1024 clk each; stop=1; next frame starts no earlier than 2048 clk after the stop begins (TX_GAP=1).
- RX basic: drive 8N1 0x3C at 31250 bps with the ACIA-rate jitter of ±1 tick -> rx_valid rises within 1 bit time after the stop mid-point; rx_data=0x3C; no error flags.
- Overrun: hold rx_ready=0 and send 5 bytes (DEPTH=4) -> FIFO holds the first 4; rx_overrun=1; the 5th byte is absent; err_clr clears the flag.
- Framing: send 0x55 with stop=0, then idle high -> rx_frame_err=1, no push; a subsequent 0x12 is received correctly.
- Glitch: a 2-tick low pulse on rx -> no frame started, no push, no flags.
- Back-to-back and reset: push 4 bytes in 4 consecutive clk -> tx_ready=0 after the 4th (one byte is in flight after the first tick). Assert reset mid-frame -> tx=1 next clk, FIFOs empty, tx_ready=1.
